// File: rtl/inst_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the boot-time instruction-memory loader:
//   - state encoding localparams and the FSM state type
//   - word byte width, header byte count, derived widths
//   - next_addr(): word-address step, wraps modulo 2^32
// -----------------------------------------------------------------------------
package loader_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HDR_HI = 3'd1;
  localparam logic [2:0] ST_HDR_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] ST_CHK    = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;
  localparam logic [2:0] ST_ERR    = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    HDR_HI = ST_HDR_HI,
    HDR_LO = ST_HDR_LO,
    DATA   = ST_DATA,
    WRITE  = ST_WRITE,
    CHK    = ST_CHK,
    DONE   = ST_DONE,
    ERR    = ST_ERR
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int HDR_BYTES  = 2;
  localparam int WORD_W     = WORD_BYTES * 8;
  localparam int IDX_W      = $clog2(WORD_BYTES);

  // Byte address of the next word; natural 32-bit overflow gives the wrap.
  function automatic logic [31:0] next_addr(input logic [31:0] addr);
    return addr + 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/inst_mem_loader_byte_word_packer.sv
// -----------------------------------------------------------------------------
// byte_word_packer
// Packs accepted stream bytes into a big-endian word: the first byte of a word
// ends up in the most significant byte.
// Ports:
//   i_CLK         clock
//   reset         synchronous, active-low reset
//   clr_i         discard partial word (header completion)
//   byte_en_i     a data byte transfers this cycle
//   byte_i        the data byte
//   word_o        shift register contents (complete word after word_ready_o)
//   last_byte_o   the next accepted byte completes the word
//   word_ready_o  one-cycle pulse in the cycle after a word's last byte
// -----------------------------------------------------------------------------
module byte_word_packer
  import loader_pkg::*;
(
  input  logic              i_CLK,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              byte_en_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              last_byte_o,
  output logic              word_ready_o
);

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              rdy_q, rdy_d;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    rdy_d   = 1'b0;
    if (clr_i) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (byte_en_i) begin
      shift_d = {shift_q[WORD_W-9:0], byte_i};
      idx_d   = idx_q + 1'b1;
      rdy_d   = (idx_q == IDX_W'(WORD_BYTES - 1));
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      rdy_q   <= rdy_d;
    end
  end

  assign word_o       = shift_q;
  assign last_byte_o  = (idx_q == IDX_W'(WORD_BYTES - 1));
  assign word_ready_o = rdy_q;

endmodule

// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
// Boot-time instruction-memory writer. Receives a byte stream (16-bit word
// count N, high byte first, then N big-endian 32-bit words), writes each word
// to the processor's instruction-load port, and keeps the processor in reset
// until the whole program has been written.
// Optional feature: define LOADER_CHECKSUM_EN to require one trailing byte
// equal to the XOR of all data bytes before releasing the processor.
// Parameters:
//   BASE_ADDR     byte address of the first word
//   MAX_WORDS     largest legal word count
// Ports:
//   i_CLK         clock
//   reset         synchronous, active-low reset
//   i_byte        stream byte
//   i_byte_valid  i_byte is valid
//   o_byte_ready  loader accepts a byte this cycle
//   o_InstLd      instruction write strobe, one cycle per word
//   o_InstAddr    write byte address
//   o_InstExt     write data
//   o_CpuRst      active-high processor reset
//   o_done        load complete (sticky)
//   o_err         load aborted (sticky)
// -----------------------------------------------------------------------------
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        i_CLK,
  input  logic        reset,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic        o_InstLd,
  output logic [31:0] o_InstAddr,
  output logic [31:0] o_InstExt,
  output logic        o_CpuRst,
  output logic        o_done,
  output logic        o_err
);

  state_t      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  n_hi_q, n_hi_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        xfer;
  logic [15:0] hdr_n;
  logic        hdr_done;
  logic        data_en;
  logic        pk_last;
  logic        pk_word_ready;
  logic [31:0] pk_word;

  assign xfer     = i_byte_valid && o_byte_ready;
  assign hdr_n    = {n_hi_q, i_byte};
  assign hdr_done = (state_q == HDR_LO) && xfer;
  assign data_en  = (state_q == DATA) && xfer;

  byte_word_packer u_packer (
    .i_CLK        (i_CLK),
    .reset        (reset),
    .clr_i        (hdr_done),
    .byte_en_i    (data_en),
    .byte_i       (i_byte),
    .word_o       (pk_word),
    .last_byte_o  (pk_last),
    .word_ready_o (pk_word_ready)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    n_hi_d  = n_hi_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: state_d = HDR_HI;
      HDR_HI: begin
        if (xfer) begin
          n_hi_d  = i_byte;
          state_d = HDR_LO;
        end
      end
      HDR_LO: begin
        if (xfer) begin
          n_d   = hdr_n;
          cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d = '0;
`endif
          if (hdr_n == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          end else if ({16'd0, hdr_n} > 32'(MAX_WORDS)) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ i_byte;
`endif
          if (pk_last) state_d = WRITE;
        end
      end
      WRITE: begin
        // The packer's pulse coincides with this state; it gates the
        // bookkeeping so counter and address only move on a real word.
        if (pk_word_ready) begin
          cnt_d  = cnt_q + 16'd1;
          addr_d = next_addr(addr_q);
        end
        if (cnt_q + 16'd1 == n_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (xfer) state_d = (i_byte == csum_q) ? DONE : ERR;
      end
`endif
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (!reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      addr_q  <= BASE_ADDR;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Header high byte and running checksum are always rewritten before use.
  always_ff @(posedge i_CLK) begin
    n_hi_q <= n_hi_d;
`ifdef LOADER_CHECKSUM_EN
    csum_q <= csum_d;
`endif
  end

  // All handshake/status outputs decode the state register only.
  always_comb begin
    o_byte_ready = 1'b0;
    o_InstLd     = 1'b0;
    o_CpuRst     = 1'b1;
    o_done       = 1'b0;
    o_err        = 1'b0;
    case (state_q)
      HDR_HI, HDR_LO, DATA, CHK: o_byte_ready = 1'b1;
      WRITE:                     o_InstLd     = 1'b1;
      DONE: begin
        o_done   = 1'b1;
        o_CpuRst = 1'b0;
      end
      ERR:                       o_err        = 1'b1;
      default:                   o_byte_ready = 1'b0;
    endcase
  end

  assign o_InstAddr = addr_q;
  assign o_InstExt  = pk_word;

endmodule

// File: tb/tb_inst_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_mem_loader
// Two loader instances (default base and base 0x400000) share one stimulus
// stream. A table of load vectors is replayed; expected writes are queued as
// bytes are driven and popped when o_InstLd is seen.
// -----------------------------------------------------------------------------
module tb_inst_mem_loader;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0040_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       valid = 1'b0;

  logic        r0, ld0, cpu0, done0, err0;
  logic [31:0] a0, e0;
  logic        r1, ld1, cpu1, done1, err1;
  logic [31:0] a1, e1;

  inst_mem_loader #(.BASE_ADDR(BASE0), .MAX_WORDS(1024)) dut0 (
    .i_CLK(clk), .reset(rst_n), .i_byte(byte_in), .i_byte_valid(valid),
    .o_byte_ready(r0), .o_InstLd(ld0), .o_InstAddr(a0), .o_InstExt(e0),
    .o_CpuRst(cpu0), .o_done(done0), .o_err(err0)
  );

  inst_mem_loader #(.BASE_ADDR(BASE1), .MAX_WORDS(1024)) dut1 (
    .i_CLK(clk), .reset(rst_n), .i_byte(byte_in), .i_byte_valid(valid),
    .o_byte_ready(r1), .o_InstLd(ld1), .o_InstAddr(a1), .o_InstExt(e1),
    .o_CpuRst(cpu1), .o_done(done1), .o_err(err1)
  );

  typedef struct packed {
    logic [15:0]  n;
    logic [127:0] words;   // word k at [k*32 +: 32]
    logic [1:0]   max_gap;
    logic         exp_err;
  } vec_t;

  vec_t vecs [6];

  int tests = 0;
  int fails = 0;
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];
  logic prev0 = 1'b0;
  logic prev1 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and check any write strobe seen there.
  task automatic tick();
    logic [63:0] ex;
    @(negedge clk);
    if (ld0) begin
      chk("ld0_not_back_to_back", {31'd0, prev0}, 32'd0);
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL ld0_unexpected: addr %h data %h, expected no write", a0, e0);
      end else begin
        ex = q0.pop_front();
        chk("ld0_addr", a0, ex[63:32]);
        chk("ld0_data", e0, ex[31:0]);
      end
    end
    if (ld1) begin
      chk("ld1_not_back_to_back", {31'd0, prev1}, 32'd0);
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL ld1_unexpected: addr %h data %h, expected no write", a1, e1);
      end else begin
        ex = q1.pop_front();
        chk("ld1_addr", a1, ex[63:32]);
        chk("ld1_data", e1, ex[31:0]);
      end
    end
    prev0 = ld0;
    prev1 = ld1;
  endtask

  // Present one byte after a gap; returns at the falling edge after transfer.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    valid = 1'b0;
    repeat (gap) tick();
    valid   = 1'b1;
    byte_in = b;
    n = 0;
    while (!r0 && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) begin
      tests++; fails++;
      $display("FAIL send_timeout: byte %h not accepted within 50 cycles, expected ready", b);
    end
    tick();
    valid = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    valid = 1'b0;
    tick();
    tick();
    q0.delete();
    q1.delete();
    chk("rst_ready",  {31'd0, r0},   32'd0);
    chk("rst_ld",     {31'd0, ld0},  32'd0);
    chk("rst_addr0",  a0,            BASE0);
    chk("rst_addr1",  a1,            BASE1);
    chk("rst_ext",    e0,            32'd0);
    chk("rst_cpurst", {31'd0, cpu0}, 32'd1);
    chk("rst_done",   {31'd0, done0}, 32'd0);
    chk("rst_err",    {31'd0, err1}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("idle_ready_low", {31'd0, r0}, 32'd0);
    tick();
    chk("hdr_ready_high", {31'd0, r0}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0]  csum;
    logic [31:0] w;
    logic [7:0]  b;
    logic        last_data;
    do_reset();
    send_byte(v.n[15:8], $urandom_range(0, v.max_gap));
    send_byte(v.n[7:0], $urandom_range(0, v.max_gap));
    if (v.exp_err) begin
      chk("err_set",       {31'd0, err0},  32'd1);
      chk("err_set1",      {31'd0, err1},  32'd1);
      chk("err_cpurst",    {31'd0, cpu0},  32'd1);
      chk("err_ready",     {31'd0, r0},    32'd0);
      chk("err_done",      {31'd0, done0}, 32'd0);
      valid   = 1'b1;
      byte_in = 8'h55;
      repeat (4) tick();
      valid = 1'b0;
      chk("err_sticky",    {31'd0, err0},  32'd1);
      chk("err_ready_hold", {31'd0, r1},   32'd0);
      chk("err_cpurst_hold", {31'd0, cpu1}, 32'd1);
      return;
    end
    csum = 8'h00;
    for (int k = 0; k < int'(v.n); k++) begin
      w = v.words[k*32 +: 32];
      for (int j = 0; j < 4; j++) begin
        b = w[31 - 8*j -: 8];
        csum ^= b;
        if (j == 3) begin
          q0.push_back({BASE0 + 32'(4*k), w});
          q1.push_back({BASE1 + 32'(4*k), w});
        end
        send_byte(b, $urandom_range(0, v.max_gap));
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(csum, 0);
    last_data = 1'b0;
`else
    last_data = (v.n != 16'd0);
`endif
    if (last_data) begin
      chk("final_write_ld",   {31'd0, ld0},   32'd1);
      chk("final_write_done", {31'd0, done0}, 32'd0);
      tick();
    end
    chk("done_rise",    {31'd0, done0}, 32'd1);
    chk("done_rise1",   {31'd0, done1}, 32'd1);
    chk("cpurst_fall",  {31'd0, cpu0},  32'd0);
    chk("done_no_err",  {31'd0, err0},  32'd0);
    chk("writes_drained0", 32'(q0.size()), 32'd0);
    chk("writes_drained1", 32'(q1.size()), 32'd0);
    repeat (3) tick();
    chk("done_sticky",   {31'd0, done0}, 32'd1);
    chk("cpurst_stays",  {31'd0, cpu1},  32'd0);
    chk("done_ready",    {31'd0, r0},    32'd0);
  endtask

  initial begin
    vecs[0] = '{n: 16'd1, words: {96'd0, 32'h2001_0001}, max_gap: 2'd0, exp_err: 1'b0};
    vecs[1] = '{n: 16'd3, words: {32'd0, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                max_gap: 2'd3, exp_err: 1'b0};
    vecs[2] = '{n: 16'd0, words: 128'd0, max_gap: 2'd0, exp_err: 1'b0};
    vecs[3] = '{n: 16'h0401, words: 128'd0, max_gap: 2'd1, exp_err: 1'b1};
    vecs[4] = '{n: 16'd2, words: {64'd0, 32'h0123_4567, 32'hCAFE_BABE}, max_gap: 2'd1, exp_err: 1'b0};
    vecs[5] = '{n: 16'd2, words: {64'd0, 32'h0F0F_0F0F, 32'hA5A5_A5A5}, max_gap: 2'd2, exp_err: 1'b0};

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset in the middle of word 0: partial bytes must not leak into the reload.
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 1);
    chk("partial_no_write", a0, BASE0);
    run_vec(vecs[4]);

`ifdef LOADER_CHECKSUM_EN
    // Wrong trailing checksum: A5A5A5A5 ^ 0F0F0F0F byte-wise XOR is 00.
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    q0.push_back({BASE0, 32'hA5A5_A5A5});
    q1.push_back({BASE1, 32'hA5A5_A5A5});
    q0.push_back({BASE0 + 32'd4, 32'h0F0F_0F0F});
    q1.push_back({BASE1 + 32'd4, 32'h0F0F_0F0F});
    for (int j = 0; j < 4; j++) send_byte(8'hA5, 0);
    for (int j = 0; j < 4; j++) send_byte(8'h0F, 0);
    send_byte(8'h01, 0);
    chk("chk_bad_err",    {31'd0, err0},  32'd1);
    chk("chk_bad_cpurst", {31'd0, cpu0},  32'd1);
    chk("chk_bad_done",   {31'd0, done0}, 32'd0);
    chk("chk_bad_drained", 32'(q0.size()), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
